incline_cond: RTL and testbench

Downstream consumer of the inertial interface's vld/incline output in the e-bike controller.
- Saturates the raw 13-bit signed incline to 10 bits.
- Low-pass filters it with a first-order exponential average.
- Reports warm-up completion and runs an IMU-alive watchdog that flags a sensor fault when incline samples stop arriving.
- Outputs feed the sensor-conditioning / assist-level logic.

---
 rtl/incline_cond.sv | 163 ++++++++++++++++
 tb/tb_incline_cond.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/incline_cond.sv
// Incline conditioning: saturates the raw IMU incline to 10 bits, low-pass filters it,
// tracks filter warm-up and runs an IMU-alive watchdog that latches a sensor fault.
module incline_cond #(
  parameter int unsigned AVG_SHIFT = 4,
  parameter int unsigned WARMUP    = 8,
  parameter int unsigned FAST_SIM  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [12:0] incline,
  input  logic        clr_fault,
  output logic [9:0]  incline_sat,
  output logic [9:0]  incline_filt,
  output logic        filt_vld,
  output logic        avg_rdy,
  output logic        sensor_fault
);

  localparam int unsigned SAT_W = 10;
  localparam int unsigned ACC_W = SAT_W + AVG_SHIFT;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WD_W  = 18;
  localparam logic [WD_W-1:0] WD_TERM = (FAST_SIM != 0) ? WD_W'(1023) : WD_W'(262143);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    sat_vld_q, sat_vld_d;
  logic [SAT_W-1:0]        incline_sat_q, incline_sat_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [SAT_W-1:0]        filt_q, filt_d;
  logic                    filt_vld_q, filt_vld_d;
  logic                    avg_rdy_q, avg_rdy_d;
  logic                    fault_q, fault_d;

  logic [SAT_W-1:0]        sat_c;
  logic                    accept_c;
  logic signed [ACC_W-1:0] samp_ext_c;
  logic signed [ACC_W-1:0] seed_c;
  logic signed [ACC_W-1:0] acc_upd_c;

  // Clamp to the 10-bit signed range: bits 12..9 must all match the sign to fit.
  always_comb begin
    sat_c = incline[SAT_W-1:0];
    if (!incline[12] && (|incline[11:9])) begin
      sat_c = 10'h1FF;
    end else if (incline[12] && !(&incline[11:9])) begin
      sat_c = 10'h200;
    end
  end

  // Filter arithmetic: seed scales the sample up so the first average equals it.
  always_comb begin
    samp_ext_c = {{AVG_SHIFT{incline_sat_q[SAT_W-1]}}, incline_sat_q};
    seed_c     = {incline_sat_q, {AVG_SHIFT{1'b0}}};
    acc_upd_c  = acc_q - (acc_q >>> AVG_SHIFT) + samp_ext_c;
  end

  assign accept_c = vld && !clr_fault && (state_q != S_FAULT);

  always_comb begin
    state_d       = state_q;
    sat_vld_d     = 1'b0;
    incline_sat_d = incline_sat_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    wd_d          = '0;
    fault_d       = fault_q;
    filt_vld_d    = 1'b0;

    if (clr_fault) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      fault_d = 1'b0;
    end else begin
      if (accept_c) begin
        sat_vld_d     = 1'b1;
        incline_sat_d = sat_c;
      end
      case (state_q)
        S_IDLE: begin
          if (sat_vld_q) begin
            acc_d      = seed_c;
            cnt_d      = CNT_W'(1);
            filt_vld_d = 1'b1;
            state_d    = (WARMUP == 1) ? S_RUN : S_FILL;
          end
        end
        S_FILL, S_RUN: begin
          // Terminal count only trips when no sample arrives in the same cycle.
          if ((wd_q == WD_TERM) && !vld) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            wd_d = vld ? '0 : wd_q + WD_W'(1);
            if (sat_vld_q) begin
              acc_d      = acc_upd_c;
              filt_vld_d = 1'b1;
              if (state_q == S_FILL) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WARMUP)) begin
                  state_d = S_RUN;
                end
              end
            end
          end
        end
        S_FAULT: begin
          fault_d = 1'b1;
        end
        default: ;
      endcase
      if (state_d != state_q) begin
        wd_d = '0;
      end
    end

    filt_d    = (state_d == S_FAULT) ? '0 : SAT_W'(acc_d >>> AVG_SHIFT);
    avg_rdy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sat_vld_q     <= 1'b0;
      incline_sat_q <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      filt_q        <= '0;
      filt_vld_q    <= 1'b0;
      avg_rdy_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sat_vld_q     <= sat_vld_d;
      incline_sat_q <= incline_sat_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      filt_q        <= filt_d;
      filt_vld_q    <= filt_vld_d;
      avg_rdy_q     <= avg_rdy_d;
      fault_q       <= fault_d;
    end
  end

  assign incline_sat  = incline_sat_q;
  assign incline_filt = filt_q;
  assign filt_vld     = filt_vld_q;
  assign avg_rdy      = avg_rdy_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_incline_cond.sv
// Directed bench for incline_cond: saturation, seeding/warm-up, step response,
// pipelining, watchdog timing and boundaries, clear and asynchronous reset.
module tb_incline_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [12:0] incline = '0;
  logic        clr_fault = 1'b0;
  logic [9:0]  incline_sat;
  logic [9:0]  incline_filt;
  logic        filt_vld;
  logic        avg_rdy;
  logic        sensor_fault;

  int checks = 0;
  int failures = 0;

  incline_cond #(.AVG_SHIFT(4), .WARMUP(8), .FAST_SIM(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .incline      (incline),
    .clr_fault    (clr_fault),
    .incline_sat  (incline_sat),
    .incline_filt (incline_filt),
    .filt_vld     (filt_vld),
    .avg_rdy      (avg_rdy),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after the posedge that sampled the pulse.
  task automatic pulse(input logic [12:0] v);
    @(negedge clk);
    vld = 1'b1;
    incline = v;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    checks++; if (incline_sat !== 10'h000) begin failures++; $display("FAIL rst_sat actual=%h expected=000", incline_sat); end
    checks++; if (incline_filt !== 10'h000) begin failures++; $display("FAIL rst_filt actual=%h expected=000", incline_filt); end
    checks++; if ({filt_vld, avg_rdy, sensor_fault} !== 3'b000) begin failures++; $display("FAIL rst_flags actual=%b expected=000", {filt_vld, avg_rdy, sensor_fault}); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_saturation();
    logic [12:0] vin [5];
    logic [9:0]  vexp [5];
    vin[0] = 13'h0FFF; vexp[0] = 10'h1FF;
    vin[1] = 13'h1000; vexp[1] = 10'h200;
    vin[2] = 13'd300;  vexp[2] = 10'd300;
    vin[3] = 13'h1E00; vexp[3] = 10'h200;
    vin[4] = 13'd512;  vexp[4] = 10'h1FF;
    for (int i = 0; i < 5; i++) begin
      pulse(vin[i]);
      checks++;
      if (incline_sat !== vexp[i]) begin
        failures++; $display("FAIL sat_%0d actual=%h expected=%h", i, incline_sat, vexp[i]);
      end
    end
  endtask

  task automatic test_seed_warmup();
    do_clr();
    step(1);
    checks++; if (incline_filt !== 10'h000) begin failures++; $display("FAIL clr_filt actual=%h expected=000", incline_filt); end
    pulse(13'd100);
    checks++; if (filt_vld !== 1'b0) begin failures++; $display("FAIL seed_vld_early actual=%b expected=0", filt_vld); end
    step(1);
    checks++; if (incline_filt !== 10'd100) begin failures++; $display("FAIL seed_filt actual=%h expected=%h", incline_filt, 10'd100); end
    checks++; if (filt_vld !== 1'b1) begin failures++; $display("FAIL seed_vld actual=%b expected=1", filt_vld); end
    step(1);
    checks++; if (filt_vld !== 1'b0) begin failures++; $display("FAIL seed_vld_width actual=%b expected=0", filt_vld); end
    checks++; if (avg_rdy !== 1'b0) begin failures++; $display("FAIL warm_1 actual=%b expected=0", avg_rdy); end
    for (int i = 2; i <= 8; i++) begin
      pulse(13'd100);
      step(1);
      checks++;
      if (avg_rdy !== (i == 8)) begin
        failures++; $display("FAIL warm_%0d actual=%b expected=%b", i, avg_rdy, (i == 8));
      end
    end
  endtask

  task automatic test_step();
    int prev;
    int cur;
    bit mono_bad;
    bit reached;
    bit hold_bad;
    do_clr();
    pulse(13'd0);
    step(2);
    @(negedge clk);
    vld = 1'b1;
    incline = 13'd160;
    step(2);
    checks++; if (incline_filt !== 10'd10) begin failures++; $display("FAIL step_first actual=%0d expected=10", $signed(incline_filt)); end
    prev = 10;
    mono_bad = 1'b0;
    reached = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      cur = int'($signed(incline_filt));
      if (cur < prev) mono_bad = 1'b1;
      if (reached && cur != 160) hold_bad = 1'b1;
      if (cur == 160) reached = 1'b1;
      prev = cur;
    end
    vld = 1'b0;
    step(3);
    checks++; if (mono_bad !== 1'b0) begin failures++; $display("FAIL step_monotonic actual=%b expected=0", mono_bad); end
    checks++; if (hold_bad !== 1'b0) begin failures++; $display("FAIL step_hold actual=%b expected=0", hold_bad); end
    checks++; if (incline_filt !== 10'd160) begin failures++; $display("FAIL step_final actual=%0d expected=160", $signed(incline_filt)); end
    checks++; if (avg_rdy !== 1'b1) begin failures++; $display("FAIL step_rdy actual=%b expected=1", avg_rdy); end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    @(negedge clk);
    vld = 1'b1;
    incline = 13'd160;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 20) vld = 1'b0;
      if (filt_vld === 1'b1) n++;
    end
    checks++; if (n != 20) begin failures++; $display("FAIL b2b_count actual=%0d expected=20", n); end
  endtask

  task automatic test_watchdog();
    int n;
    int fv;
    pulse(13'd160);
    n = 1;
    while (sensor_fault !== 1'b1 && n < 3000) begin
      step(1);
      n++;
    end
    checks++; if (n != 1025) begin failures++; $display("FAIL wd_latency actual=%0d expected=1025", n); end
    checks++; if (incline_filt !== 10'h000) begin failures++; $display("FAIL wd_filt actual=%h expected=000", incline_filt); end
    checks++; if (avg_rdy !== 1'b0) begin failures++; $display("FAIL wd_rdy actual=%b expected=0", avg_rdy); end
    pulse(13'd77);
    fv = 0;
    for (int i = 0; i < 4; i++) begin
      if (filt_vld === 1'b1) fv++;
      step(1);
    end
    checks++; if (fv != 0) begin failures++; $display("FAIL wd_ignore_vld actual=%0d expected=0", fv); end
    checks++; if (incline_sat !== 10'd160) begin failures++; $display("FAIL wd_sat_hold actual=%h expected=%h", incline_sat, 10'd160); end
    do_clr();
    checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL wd_clr actual=%b expected=0", sensor_fault); end
    pulse(13'h1FCE);
    step(1);
    checks++; if (incline_filt !== 10'h3CE) begin failures++; $display("FAIL wd_reseed actual=%0d expected=-50", $signed(incline_filt)); end
    checks++; if (filt_vld !== 1'b1) begin failures++; $display("FAIL wd_reseed_vld actual=%b expected=1", filt_vld); end
  endtask

  task automatic test_terminal();
    @(negedge clk);
    vld = 1'b1;
    incline = 13'h1FCE;
    step(10);
    vld = 1'b0;
    checks++; if (avg_rdy !== 1'b1) begin failures++; $display("FAIL term_rdy actual=%b expected=1", avg_rdy); end
    step(1022);
    pulse(13'h1FCE);
    step(3);
    checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL term_exact actual=%b expected=0", sensor_fault); end
    step(1020);
    pulse(13'h1FCE);
    checks++; if (sensor_fault !== 1'b1) begin failures++; $display("FAIL term_late actual=%b expected=1", sensor_fault); end
  endtask

  task automatic test_clr_with_vld();
    do_clr();
    @(negedge clk);
    vld = 1'b1;
    clr_fault = 1'b1;
    incline = 13'd200;
    @(negedge clk);
    vld = 1'b0;
    clr_fault = 1'b0;
    step(2);
    checks++; if (incline_sat !== 10'h3CE) begin failures++; $display("FAIL clrvld_sat actual=%h expected=3ce", incline_sat); end
    checks++; if (incline_filt !== 10'h000) begin failures++; $display("FAIL clrvld_filt actual=%h expected=000", incline_filt); end
    pulse(13'd33);
    step(1);
    checks++; if (incline_filt !== 10'd33) begin failures++; $display("FAIL clrvld_reseed actual=%0d expected=33", $signed(incline_filt)); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    vld = 1'b1;
    incline = 13'd20;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (incline_sat !== 10'h000) begin failures++; $display("FAIL midrst_sat actual=%h expected=000", incline_sat); end
    checks++; if (incline_filt !== 10'h000) begin failures++; $display("FAIL midrst_filt actual=%h expected=000", incline_filt); end
    checks++; if ({filt_vld, avg_rdy, sensor_fault} !== 3'b000) begin failures++; $display("FAIL midrst_flags actual=%b expected=000", {filt_vld, avg_rdy, sensor_fault}); end
    @(negedge clk);
    vld = 1'b0;
    step(1);
    rst_n = 1'b1;
    pulse(13'h1FF9);
    step(1);
    checks++; if (incline_filt !== 10'h3F9) begin failures++; $display("FAIL midrst_reseed actual=%0d expected=-7", $signed(incline_filt)); end
    checks++; if (avg_rdy !== 1'b0) begin failures++; $display("FAIL midrst_rdy actual=%b expected=0", avg_rdy); end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_seed_warmup();
    test_step();
    test_back_to_back();
    test_watchdog();
    test_terminal();
    test_clr_with_vld();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
